sdram_bus_arb: RTL and testbench
================================

# sdram_bus_arb

Two-master, one-slave arbiter for the simple valid/ready SDRAM system bus. It sits directly downstream of the virtual-JTAG host controller (master 0) and a second on-chip master (master 1, e.g. a pattern generator), and drives the SDRAM controller's request port. Arbitration is round-robin. Read responses, which return in order some cycles later, are routed back to the issuing master through an in-order ID FIFO.

## Interface
- AW, 16, address width
- DW, 16, data width
- MAX_OUT, 4, max outstanding reads; power of 2, ≥2

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- m0_address / m1_address  in  AW  master address
- m0_wvalid / m1_wvalid  in  1  write request; held until wready
- m0_wdata / m1_wdata  in  DW  write data
- m0_wready / m1_wready  out  1  write accepted
- m0_rvalid / m1_rvalid  in  1  read request; held until rready
- m0_rready / m1_rready  out  1  read accepted
- m0_rrvalid / m1_rrvalid  out  1  read data valid for this master
- m0_rdata / m1_rdata  out  DW  read data; both driven from s_rdata
- s_address  out  AW  to SDRAM controller
- s_wvalid, s_rvalid  out  1  forwarded requests
- s_wdata  out  DW  forwarded write data
- s_wready, s_rready  in  1  slave accept
- s_rrvalid  in  1  slave read response valid; responses arrive in request order
- s_rdata  in  DW  slave read data
- err_unexp_rsp  out  1  sticky flag; s_rrvalid seen with no outstanding read

## Operation
- FSM states:
  - IDLE: no grant; all s_*valid = 0; m*_wready / m*_rready = 0.
  - BUSY: grant register `gnt` selects one master.
- Eligibility in IDLE: master eligible if wvalid = 1, or if rvalid = 1 and the ID FIFO is not full.
  - If a master asserts wvalid and rvalid together, the write is taken.
- Round-robin: register `last` (reset 1) holds the most recently granted master.
  - If both masters are eligible, grant goes to !last.
  - Otherwise grant goes to the single eligible master.
  - Eligible master present: gnt <= winner, go to BUSY.
- In BUSY:
  - s_address, s_wdata, s_wvalid, s_rvalid = granted master's signals, combinational.
  - Granted master's wready/rready = s_wready/s_rready, combinational. Non-granted master sees 0.
- Handshake (s_wvalid & s_wready, or s_rvalid & s_rready):
  - last <= gnt; return to IDLE.
  - On a read handshake, push gnt into the ID FIFO.
- If the granted master drops both valids while in BUSY (protocol violation), return to IDLE with no transfer. `last` is not updated.
- Response routing:
  - s_rrvalid with FIFO non-empty: assert m[head]_rrvalid the same cycle (combinational), then pop.
  - s_rrvalid with FIFO empty: no master sees it; err_unexp_rsp <= 1 (cleared only by reset).
- Simultaneous push and pop: count unchanged; both take effect.
- Count range 0..MAX_OUT. Pointers are log2(MAX_OUT) bits and wrap naturally.

## Timing
- Reset values:
  - state = IDLE, last = 1, FIFO empty, err_unexp_rsp = 0.
  - All s_*valid, m*_wready, m*_rready and m*_rrvalid = 0.
- Arbitration latency: request seen in IDLE at cycle N → s_*valid = 1 at cycle N+1.
  - If s_*ready is already 1, the master's ready pulses at N+1.
- Minimum spacing: back-to-back transfers from one master are 2 cycles apart (handshake cycle, then one IDLE cycle).
- Response path has zero latency: m*_rrvalid and m*_rdata follow s_rrvalid and s_rdata in the same cycle.
- Reset mid-transaction: grant, FIFO and error flag clear on the next edge. Outstanding responses are discarded. The SDRAM controller shares rst_n, so it is reset in the same cycle.

## Structure
- Package sdram_bus_pkg holds:
  - state enum {IDLE, BUSY};
  - master-ID typedef (1 bit);
  - constants NUM_MASTERS = 2.
- Sub-module sync_fifo: synchronous FIFO, parameters WIDTH = 1 and DEPTH = MAX_OUT.
  - Ports push, pop, din, dout (head), full, empty.
  - Same clk / rst_n.
- Request muxing and the response demux live in the top module.

## Test plan
- Single write from m0 (addr 0x0010, data 0xBEEF), s_wready = 1 → s_wvalid at N+1 with those values; m0_wready pulses once; m1_wready stays 0.
- m0 and m1 both request reads every cycle after reset → grants alternate m0, m1, m0, m1; responses 0x1111, 0x2222, 0x3333, 0x4444 returned with latency 3 arrive on m0, m1, m0, m1 rrvalid respectively.
- Read backpressure: s_rrvalid held 0; m1 issues 5 reads → first 4 accepted, 5th not granted until one s_rrvalid pops the FIFO; a m0 write during this time is granted.
- Wrap-around: 12 m0 reads at MAX_OUT = 4, responses delayed 2 cycles → all 12 responses routed to m0; FIFO never exceeds 4 entries; push and pop in the same cycle leave count unchanged.
- s_rrvalid pulsed with FIFO empty → no m*_rrvalid; err_unexp_rsp = 1 and stays 1 until rst_n = 0.
- rst_n asserted with 2 reads outstanding and a write in BUSY → next cycle state IDLE, all valids/readies 0; later stray s_rrvalid sets err_unexp_rsp.

Source files
------------

// File: rtl/sdram_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sdram_bus_pkg
// Description : Shared types and constants for the SDRAM system-bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_bus_pkg;

  // Number of masters sharing the SDRAM request port
  localparam int NUM_MASTERS = 2;

  // Master identifier carried through the read-ID FIFO
  typedef logic [0:0] mid_t;

  // Arbiter state: no grant, or one master owns the slave port
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with combinational head output. A push into
//               a full FIFO is accepted only when a pop happens the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because count gates validity
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally; count tracks occupancy 0..DEPTH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : sdram_bus_arb
// Description : Two-master round-robin arbiter in front of the SDRAM
//               controller request port. Read responses return in order and
//               are steered back to the issuing master via an ID FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_bus_arb
  import sdram_bus_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m0_address,
  input  logic          m0_wvalid,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_wready,
  input  logic          m0_rvalid,
  output logic          m0_rready,
  output logic          m0_rrvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic [AW-1:0] m1_address,
  input  logic          m1_wvalid,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_wready,
  input  logic          m1_rvalid,
  output logic          m1_rready,
  output logic          m1_rrvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] s_address,
  output logic          s_wvalid,
  output logic          s_rvalid,
  output logic [DW-1:0] s_wdata,
  input  logic          s_wready,
  input  logic          s_rready,
  input  logic          s_rrvalid,
  input  logic [DW-1:0] s_rdata,
  output logic          err_unexp_rsp
);

  localparam int IDW = $clog2(NUM_MASTERS);

  state_t          r_state;
  state_t          w_state_nxt;
  mid_t            r_gnt;
  mid_t            w_gnt_nxt;
  mid_t            r_last;
  mid_t            w_last_nxt;
  logic            r_err;

  logic            w_elig0;
  logic            w_elig1;
  logic            w_g_wvalid;
  logic            w_g_rvalid;
  logic [AW-1:0]   w_g_address;
  logic [DW-1:0]   w_g_wdata;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [IDW-1:0]  w_head;

  // A read is only eligible while the ID FIFO has room; writes always are
  assign w_elig0 = m0_wvalid | (m0_rvalid & ~w_full);
  assign w_elig1 = m1_wvalid | (m1_rvalid & ~w_full);

  assign w_g_wvalid  = (r_gnt == 1'b0) ? m0_wvalid  : m1_wvalid;
  assign w_g_rvalid  = (r_gnt == 1'b0) ? m0_rvalid  : m1_rvalid;
  assign w_g_address = (r_gnt == 1'b0) ? m0_address : m1_address;
  assign w_g_wdata   = (r_gnt == 1'b0) ? m0_wdata   : m1_wdata;

  // Next-state, grant selection and slave-side request muxing
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    s_address   = '0;
    s_wdata     = '0;
    s_wvalid    = 1'b0;
    s_rvalid    = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_elig0 | w_elig1) begin
          w_state_nxt = BUSY;
          if (w_elig0 & w_elig1) begin
            w_gnt_nxt = ~r_last;
          end else begin
            w_gnt_nxt = w_elig1 ? 1'b1 : 1'b0;
          end
        end
      end
      BUSY: begin
        s_address = w_g_address;
        s_wdata   = w_g_wdata;
        s_wvalid  = w_g_wvalid;
        // A write wins over a read presented in the same cycle
        s_rvalid  = w_g_rvalid & ~w_g_wvalid;
        if ((s_wvalid & s_wready) | (s_rvalid & s_rready)) begin
          w_last_nxt  = r_gnt;
          w_state_nxt = IDLE;
          w_push      = s_rvalid & s_rready;
        end else if (!w_g_wvalid && !w_g_rvalid) begin
          // Master withdrew its request: release without a transfer
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, grant and round-robin history registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Readies only reach the granted master, and only for the request type
  // actually forwarded, so a master holding both valids never sees rready
  assign m0_wready = (r_gnt == 1'b0) & s_wvalid & s_wready;
  assign m1_wready = (r_gnt == 1'b1) & s_wvalid & s_wready;
  assign m0_rready = (r_gnt == 1'b0) & s_rvalid & s_rready;
  assign m1_rready = (r_gnt == 1'b1) & s_rvalid & s_rready;

  sync_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_gnt),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Responses are steered by the FIFO head with no added latency
  assign w_pop      = s_rrvalid & ~w_empty;
  assign m0_rrvalid = w_pop & (w_head == 1'b0);
  assign m1_rrvalid = w_pop & (w_head == 1'b1);
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (s_rrvalid && w_empty) begin
      r_err <= 1'b1;
    end
  end

  assign err_unexp_rsp = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_bus_arb
// Description : Scoreboard bench for sdram_bus_arb with a behavioural slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_bus_arb;

  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic [AW-1:0] m_address [2];
  logic          m_wvalid  [2];
  logic          m_rvalid  [2];
  logic [DW-1:0] m_wdata   [2];

  logic          m0_wready, m1_wready, m0_rready, m1_rready;
  logic          m0_rrvalid, m1_rrvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] s_address;
  logic          s_wvalid, s_rvalid;
  logic [DW-1:0] s_wdata;
  logic          s_wready, s_rready, s_rrvalid;
  logic [DW-1:0] s_rdata;
  logic          err_unexp_rsp;

  sdram_bus_arb #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m_address[0]), .m0_wvalid(m_wvalid[0]), .m0_wdata(m_wdata[0]),
    .m0_wready(m0_wready), .m0_rvalid(m_rvalid[0]), .m0_rready(m0_rready),
    .m0_rrvalid(m0_rrvalid), .m0_rdata(m0_rdata),
    .m1_address(m_address[1]), .m1_wvalid(m_wvalid[1]), .m1_wdata(m_wdata[1]),
    .m1_wready(m1_wready), .m1_rvalid(m_rvalid[1]), .m1_rready(m1_rready),
    .m1_rrvalid(m1_rrvalid), .m1_rdata(m1_rdata),
    .s_address(s_address), .s_wvalid(s_wvalid), .s_rvalid(s_rvalid),
    .s_wdata(s_wdata), .s_wready(s_wready), .s_rready(s_rready),
    .s_rrvalid(s_rrvalid), .s_rdata(s_rdata), .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Owner of every transaction is encoded in address bit 15 (m1 = 1)
  typedef struct packed { logic m; logic [15:0] d; } rexp_t;
  typedef struct packed { logic [15:0] a; logic [15:0] d; } wexp_t;
  typedef struct packed { int due; logic [15:0] d; } pend_t;

  rexp_t exp_r [$];
  wexp_t exp_w0 [$];
  wexp_t exp_w1 [$];
  pend_t pend [$];
  int    grant_log [$];

  int total = 0;
  int bad = 0;

  // Slave behaviour knobs
  bit   rdy_rand = 0, resp_en = 1, resp_rand = 0, lat_rand = 0;
  bit   data_seq = 0, stray_req = 0;
  logic cfg_wready = 0, cfg_rready = 0;
  int   lat = 3, seq_k = 0;

  // Monitor state
  bit    exp_err = 0, prev_hs = 0, hs = 0, m1_done = 0;
  int    nb = 0, rsp_cnt0 = 0, rsp_cnt1 = 0, acc_cnt = 0, l = 0;
  rexp_t re;
  wexp_t we;
  logic  own;
  logic [15:0] rd;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One master transaction; entered and left at posedge+1
  task automatic mtxn(input int m, input bit wr, input bit both,
                      input logic [15:0] a, input logic [15:0] d, input int budget);
    int n;
    bit got;
    n = 0;
    got = 0;
    m_address[m] = a;
    m_wdata[m]   = d;
    m_wvalid[m]  = wr;
    m_rvalid[m]  = !wr || both;
    if (wr) begin
      if (m == 0) exp_w0.push_back('{a: a, d: d});
      else        exp_w1.push_back('{a: a, d: d});
    end
    while (!got && n < budget) begin
      @(negedge clk);
      if (wr) got = (m == 0) ? m0_wready : m1_wready;
      else    got = (m == 0) ? m0_rready : m1_rready;
      n++;
    end
    if (!got) chk($sformatf("m%0d_timeout", m), 32'(got), 32'd1);
    @(posedge clk); #1;
    m_wvalid[m] = 1'b0;
    m_rvalid[m] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_wvalid[i] = 1'b0;
      m_rvalid[i] = 1'b0;
    end
    stray_req = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_cnt0 = 0; rsp_cnt1 = 0; acc_cnt = 0;
    grant_log.delete();
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 300 && pend.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk(tag, 32'(rsp_cnt0 + rsp_cnt1), 32'(acc_cnt));
  endtask

  // Behavioural SDRAM slave: readies and in-order read responses
  initial begin
    s_wready = 0; s_rready = 0; s_rrvalid = 0; s_rdata = '0;
    forever begin
      @(posedge clk); #1;
      s_wready  = rdy_rand ? 1'($urandom_range(0, 1)) : cfg_wready;
      s_rready  = rdy_rand ? 1'($urandom_range(0, 1)) : cfg_rready;
      s_rrvalid = 1'b0;
      s_rdata   = 16'($urandom);
      if (stray_req) begin
        s_rrvalid = 1'b1;
        stray_req = 0;
      end else if (resp_en && pend.size() > 0 && pend[0].due <= cyc &&
                   (!resp_rand || $urandom_range(0, 2) != 0)) begin
        s_rrvalid = 1'b1;
        s_rdata   = pend[0].d;
        void'(pend.pop_front());
      end
    end
  end

  // Monitor: scoreboard pops on every DUT-visible event
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_r.delete(); pend.delete(); exp_w0.delete(); exp_w1.delete();
        exp_err = 0; prev_hs = 0;
      end else begin
        chk("err_flag", 32'(err_unexp_rsp), 32'(exp_err));
        nb = exp_r.size();
        if (s_rrvalid) begin
          if (nb > 0) begin
            re = exp_r.pop_front();
            chk("rsp_route", 32'({m1_rrvalid, m0_rrvalid}), re.m ? 32'd2 : 32'd1);
            chk("rsp_data", 32'(re.m ? m1_rdata : m0_rdata), 32'(re.d));
          end else begin
            chk("rsp_stray", 32'({m1_rrvalid, m0_rrvalid}), 32'd0);
            exp_err = 1;
          end
        end else begin
          chk("rsp_quiet", 32'({m1_rrvalid, m0_rrvalid}), 32'd0);
        end
        if (m0_rrvalid) rsp_cnt0++;
        if (m1_rrvalid) rsp_cnt1++;
        hs = 0;
        if (prev_hs) chk("idle_gap", 32'({s_wvalid, s_rvalid}), 32'd0);
        if (s_wvalid && s_wready) begin
          hs  = 1;
          own = s_address[15];
          chk("wr_ready", 32'({m1_wready, m0_wready}), own ? 32'd2 : 32'd1);
          chk("wr_pending", 32'(own ? exp_w1.size() : exp_w0.size()) != 0 ? 32'd1 : 32'd0, 32'd1);
          if (own ? exp_w1.size() != 0 : exp_w0.size() != 0) begin
            we = own ? exp_w1.pop_front() : exp_w0.pop_front();
            chk("wr_addr", 32'(s_address), 32'(we.a));
            chk("wr_data", 32'(s_wdata), 32'(we.d));
          end
        end else begin
          chk("wready_quiet", 32'({m1_wready, m0_wready}), 32'd0);
        end
        if (s_rvalid && s_rready) begin
          hs  = 1;
          own = s_address[15];
          chk("rd_ready", 32'({m1_rready, m0_rready}), own ? 32'd2 : 32'd1);
          chk("rd_outstanding_ok", (nb < MAX_OUT) ? 32'd1 : 32'd0, 32'd1);
          if (data_seq) begin
            seq_k++;
            rd = 16'(32'h1111 * seq_k);
          end else begin
            rd = 16'($urandom);
          end
          l = lat_rand ? int'($urandom_range(1, 10)) : lat;
          exp_r.push_back('{m: own, d: rd});
          pend.push_back('{due: cyc + l, d: rd});
          grant_log.push_back(int'(own));
          acc_cnt++;
        end else begin
          chk("rready_quiet", 32'({m1_rready, m0_rready}), 32'd0);
        end
        prev_hs = hs;
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_address[i] = '0; m_wdata[i] = '0; m_rvalid[i] = 1'b0; m_wvalid[i] = 1'b0;
    end
    // Single write from m0, request already present as reset releases
    cfg_wready = 1; cfg_rready = 1;
    m_address[0] = 16'h0010; m_wdata[0] = 16'hBEEF; m_wvalid[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_w0.push_back('{a: 16'h0010, d: 16'hBEEF});
    @(negedge clk);
    chk("rst_s_valid", 32'({s_wvalid, s_rvalid}), 32'd0);
    chk("rst_readies", 32'({m0_wready, m1_wready, m0_rready, m1_rready}), 32'd0);
    chk("rst_rrvalid", 32'({m0_rrvalid, m1_rrvalid}), 32'd0);
    chk("rst_err", 32'(err_unexp_rsp), 32'd0);
    @(negedge clk);
    chk("w1_s_wvalid", 32'(s_wvalid), 32'd1);
    chk("w1_addr", 32'(s_address), 32'h0010);
    chk("w1_data", 32'(s_wdata), 32'hBEEF);
    chk("w1_m0_wready", 32'(m0_wready), 32'd1);
    chk("w1_m1_wready", 32'(m1_wready), 32'd0);
    @(posedge clk); #1 m_wvalid[0] = 1'b0;
    @(negedge clk);
    chk("w1_after", 32'({s_wvalid, m0_wready}), 32'd0);

    // Both masters reading continuously: grants alternate starting at m0
    do_reset();
    data_seq = 1; seq_k = 0; lat = 3;
    fork
      begin
        mtxn(0, 0, 0, 16'h0100, 16'h0, 50);
        mtxn(0, 0, 0, 16'h0101, 16'h0, 50);
      end
      begin
        mtxn(1, 0, 0, 16'h8100, 16'h0, 50);
        mtxn(1, 0, 0, 16'h8101, 16'h0, 50);
      end
    join
    drain("alt_drain");
    data_seq = 0;
    chk("alt_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk($sformatf("alt_order%0d", i), 32'(grant_log[i]), 32'(i % 2));
    chk("alt_rsp_m0", 32'(rsp_cnt0), 32'd2);
    chk("alt_rsp_m1", 32'(rsp_cnt1), 32'd2);

    // Read backpressure: fifth m1 read held off while four are outstanding
    do_reset();
    resp_en = 0; lat = 1; m1_done = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) mtxn(1, 0, 0, 16'(32'h8200 + i), 16'h0, 300);
        m1_done = 1;
      end
    join_none
    for (int k = 0; k < 60 && grant_log.size() < 4; k++) @(negedge clk);
    repeat (8) @(negedge clk);
    chk("bp_accepted", 32'(grant_log.size()), 32'd4);
    @(posedge clk); #1;
    mtxn(0, 1, 0, 16'h0300, 16'h5A5A, 40);
    chk("bp_still_held", 32'(grant_log.size()), 32'd4);
    resp_en = 1;
    for (int k = 0; k < 100 && !m1_done; k++) @(negedge clk);
    chk("bp_fifth_done", 32'(m1_done), 32'd1);
    drain("bp_drain");
    chk("bp_rsp_m1", 32'(rsp_cnt1), 32'd5);

    // Pointer wrap: twelve m0 reads with short response delay
    do_reset();
    lat = 2;
    for (int i = 0; i < 12; i++) mtxn(0, 0, 0, 16'(32'h0400 + i), 16'h0, 40);
    drain("wrap_drain");
    chk("wrap_rsp_m0", 32'(rsp_cnt0), 32'd12);
    chk("wrap_rsp_m1", 32'(rsp_cnt1), 32'd0);

    // Stray response sets the sticky error flag, cleared only by reset
    do_reset();
    stray_req = 1;
    repeat (6) @(negedge clk);
    chk("err_sticky", 32'(err_unexp_rsp), 32'd1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", 32'(err_unexp_rsp), 32'd0);

    // Reset with two reads outstanding and a write stalled in BUSY
    cfg_wready = 0;
    do_reset();
    resp_en = 0;
    mtxn(1, 0, 0, 16'h8500, 16'h0, 30);
    mtxn(1, 0, 0, 16'h8501, 16'h0, 30);
    m_address[0] = 16'h0600; m_wdata[0] = 16'h1234; m_wvalid[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_busy_wvalid", 32'(s_wvalid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; m_wvalid[0] = 1'b0; cfg_wready = 1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_valids", 32'({s_wvalid, s_rvalid}), 32'd0);
    chk("mid_readies", 32'({m0_wready, m1_wready, m0_rready, m1_rready}), 32'd0);
    stray_req = 1;
    repeat (3) @(negedge clk);
    chk("mid_err_stray", 32'(err_unexp_rsp), 32'd1);

    // Randomised traffic from both masters against random slave behaviour
    do_reset();
    resp_en = 1; rdy_rand = 1; resp_rand = 1; lat_rand = 1;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        mtxn(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
             {1'b0, 15'($urandom)}, 16'($urandom), 200);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        mtxn(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
             {1'b1, 15'($urandom)}, 16'($urandom), 200);
      end
    join
    rdy_rand = 0;
    drain("rand_drain");
    chk("rand_w0_left", 32'(exp_w0.size()), 32'd0);
    chk("rand_w1_left", 32'(exp_w1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
